// File: rtl/ro_puf.sv
// Behavioural ring-oscillator PUF: 32 counters with fixed seed-dependent rates are
// integrated over a window, and challenge-selected pairs are compared into a 16-bit response.
module ro_puf #(
    parameter int SEED   = 0,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [0:15] challenge,
    output logic [0:15] Out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [9:0] WIN_LAST = 10'(WINDOW - 1);

    // Rates are 16 + ((7k + SEED) mod 32); 7 is odd, so all 32 rates are distinct.
    function automatic logic [CNT_W-1:0] rate_of(input int k);
        return CNT_W'(32'd16 + ((32'd7 * 32'(k) + 32'(SEED)) % 32'd32));
    endfunction

    state_t            state_r;
    state_t            next_s;
    logic [9:0]        win_r;
    logic [0:15]       chal_q_r;
    logic [0:15]       out_r;
    logic [0:15]       resp_s;
    logic [CNT_W-1:0]  cnt_r [32];

    // Next-state decode; a changed challenge is only noticed once the run is finished.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                next_s = MEASURE;
            end
            MEASURE: begin
                if (win_r == WIN_LAST) begin
                    next_s = COMPARE;
                end else begin
                    next_s = MEASURE;
                end
            end
            COMPARE: begin
                next_s = DONE;
            end
            DONE: begin
                if (challenge != chal_q_r) begin
                    next_s = IDLE;
                end else begin
                    next_s = DONE;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Pair selection: bit i compares 2i against 2i+1, or against (2i+3) mod 32 when set.
    always_comb begin
        resp_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (chal_q_r[i]) begin
                resp_s[i] = (cnt_r[5'(2 * i)] > cnt_r[5'((2 * i + 3) % 32)]);
            end else begin
                resp_s[i] = (cnt_r[5'(2 * i)] > cnt_r[5'(2 * i + 1)]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Measurement window counter and challenge capture.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            win_r    <= 10'd0;
            chal_q_r <= 16'h0000;
        end else if (state_r == IDLE) begin
            win_r    <= 10'd0;
            chal_q_r <= challenge;
        end else if (state_r == MEASURE) begin
            win_r    <= win_r + 10'd1;
        end
    end

    // Emulated oscillator counters.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int k = 0; k < 32; k++) begin
                cnt_r[k] <= '0;
            end
        end else if (state_r == IDLE) begin
            for (int k = 0; k < 32; k++) begin
                cnt_r[k] <= '0;
            end
        end else if (state_r == MEASURE) begin
            for (int k = 0; k < 32; k++) begin
                cnt_r[k] <= cnt_r[k] + rate_of(k);
            end
        end
    end

    // Response register; it only moves on the compare edge so the old key survives a re-run.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            out_r <= 16'h0000;
        end else if (state_r == COMPARE) begin
            out_r <= resp_s;
        end
    end

    assign Out = out_r;

endmodule

// File: tb/tb_ro_puf.sv
// Directed bench for ro_puf: default instance plus two short-window instances (SEED 0 and 3).
module tb_ro_puf;

    logic        clk;
    logic        rst_d;
    logic [0:15] chal_d;
    logic [0:15] out_d;
    logic        rst_b;
    logic [0:15] chal_b;
    logic [0:15] out_w4;
    logic [0:15] out_s3;

    int n_cmp;
    int n_err;

    ro_puf dut (
        .clk       (clk),
        .Reset     (rst_d),
        .challenge (chal_d),
        .Out       (out_d)
    );

    ro_puf #(.SEED(0), .WINDOW(4)) dut_w4 (
        .clk       (clk),
        .Reset     (rst_b),
        .challenge (chal_b),
        .Out       (out_w4)
    );

    ro_puf #(.SEED(3), .WINDOW(4)) dut_s3 (
        .clk       (clk),
        .Reset     (rst_b),
        .challenge (chal_b),
        .Out       (out_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Two reset edges on the default instance; the next edge is edge 1 (IDLE).
    task automatic reset_default(input logic [0:15] chal);
        rst_d  = 1'b0;
        chal_d = chal;
        tick(2);
        rst_d  = 1'b1;
    endtask

    task automatic reset_short(input logic [0:15] chal);
        rst_b  = 1'b0;
        chal_b = chal;
        tick(2);
        rst_b  = 1'b1;
    endtask

    task automatic test_reset;
        rst_d  = 1'b0;
        chal_d = 16'hFFFF;
        rst_b  = 1'b0;
        chal_b = 16'hFFFF;
        for (int e = 0; e < 3; e++) begin
            tick(1);
            n_cmp++;
            if (out_d !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_out edge %0d: got %h expected 0000", e, out_d);
            end
            n_cmp++;
            if (out_w4 !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_out_w4 edge %0d: got %h expected 0000", e, out_w4);
            end
        end
    endtask

    task automatic test_zero_challenge;
        reset_default(16'h0000);
        tick(256);
        n_cmp++;
        if (out_d !== 16'h0000) begin
            n_err++;
            $display("FAIL zero_edge256: got %h expected 0000", out_d);
        end
        tick(1);
        n_cmp++;
        if (out_d !== 16'h0000) begin
            n_err++;
            $display("FAIL zero_edge257: got %h expected 0000", out_d);
        end
        tick(1);
        n_cmp++;
        if (out_d !== 16'h2050) begin
            n_err++;
            $display("FAIL zero_edge258: got %h expected 2050", out_d);
        end
        tick(5);
        n_cmp++;
        if (out_d !== 16'h2050) begin
            n_err++;
            $display("FAIL zero_stable: got %h expected 2050", out_d);
        end
    endtask

    // Entered in DONE with challenge 0 and Out 2050.
    task automatic test_challenge_change;
        chal_d = 16'hFFFF;
        tick(258);
        n_cmp++;
        if (out_d !== 16'h2050) begin
            n_err++;
            $display("FAIL change_hold: got %h expected 2050", out_d);
        end
        tick(1);
        n_cmp++;
        if (out_d !== 16'h6AF5) begin
            n_err++;
            $display("FAIL change_new: got %h expected 6af5", out_d);
        end
    endtask

    task automatic test_all_ones;
        reset_default(16'hFFFF);
        n_cmp++;
        if (out_d !== 16'h0000) begin
            n_err++;
            $display("FAIL ones_after_reset: got %h expected 0000", out_d);
        end
        tick(257);
        n_cmp++;
        if (out_d !== 16'h0000) begin
            n_err++;
            $display("FAIL ones_edge257: got %h expected 0000", out_d);
        end
        tick(1);
        n_cmp++;
        if (out_d !== 16'h6AF5) begin
            n_err++;
            $display("FAIL ones_edge258: got %h expected 6af5", out_d);
        end
    endtask

    // Abort a mixed-challenge run 100 cycles into MEASURE, then rerun it in full.
    task automatic test_mixed_reset_mid;
        reset_default(16'b1001011010111000);
        tick(101);
        rst_d = 1'b0;
        tick(2);
        n_cmp++;
        if (out_d !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_out: got %h expected 0000", out_d);
        end
        rst_d = 1'b1;
        tick(257);
        n_cmp++;
        if (out_d !== 16'h0000) begin
            n_err++;
            $display("FAIL mixed_edge257: got %h expected 0000", out_d);
        end
        tick(1);
        n_cmp++;
        if (out_d !== 16'h22F0) begin
            n_err++;
            $display("FAIL mixed_edge258: got %h expected 22f0", out_d);
        end
    endtask

    task automatic test_window4;
        reset_short(16'h0000);
        tick(5);
        n_cmp++;
        if (out_w4 !== 16'h0000) begin
            n_err++;
            $display("FAIL w4_zero_edge5: got %h expected 0000", out_w4);
        end
        tick(1);
        n_cmp++;
        if (out_w4 !== 16'h2050) begin
            n_err++;
            $display("FAIL w4_zero_edge6: got %h expected 2050", out_w4);
        end
        n_cmp++;
        if (out_s3 !== 16'h2814) begin
            n_err++;
            $display("FAIL s3_zero_edge6: got %h expected 2814", out_s3);
        end
        reset_short(16'hFFFF);
        tick(6);
        n_cmp++;
        if (out_w4 !== 16'h6AF5) begin
            n_err++;
            $display("FAIL w4_ones_edge6: got %h expected 6af5", out_w4);
        end
        n_cmp++;
        if (out_s3 !== 16'h7ABD) begin
            n_err++;
            $display("FAIL s3_ones_edge6: got %h expected 7abd", out_s3);
        end
        reset_short(16'b1001011010111000);
        tick(6);
        n_cmp++;
        if (out_w4 !== 16'h22F0) begin
            n_err++;
            $display("FAIL w4_mixed_edge6: got %h expected 22f0", out_w4);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_d  = 1'b0;
        chal_d = 16'h0000;
        rst_b  = 1'b0;
        chal_b = 16'h0000;
        test_reset();
        test_zero_challenge();
        test_challenge_change();
        test_all_ones();
        test_mixed_reset_mid();
        test_window4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
